// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d engine: FSM state encoding, output-size
// helpers and the signed saturation function.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Width of the intermediate used by saturate(); wide enough for any
  // sensible accumulator width.
  localparam int SAT_W = 128;

  // Number of valid-mode output positions along one image dimension.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Total number of outputs for an image/kernel/stride combination.
  function automatic int out_count(input int rows, input int cols,
                                   input int k, input int stride);
    return out_dim(rows, k, stride) * out_dim(cols, k, stride);
  endfunction

  // Clamp v to the signed data_w-bit range; clamped reports whether it moved.
  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] v,
    input  int                      data_w,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one     = SAT_W'(1);
    hi      = (one <<< (data_w - 1)) - one;
    lo      = -hi - one;
    clamped = 1'b0;
    if (v > hi) begin
      clamped = 1'b1;
      return hi;
    end else if (v < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Tap/output counters for the conv2d engine. rom_addr always points at the
// pixel of the current tap; on a step it moves to the next tap (taps
// row-major inside the kernel, outputs row-major across the image). The
// counters hold on the final tap of the final output.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_R  = 10,
  parameter int IMG_C  = 12,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ROM_AW = 8,
  parameter int OUT_AW = 7,
  parameter int TAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [TAP_W-1:0]  tap,
  output logic [OUT_AW-1:0] out_idx,
  output logic              last_tap,
  output logic              last_out
);

  localparam int OUT_R = out_dim(IMG_R, K, STRIDE);
  localparam int OUT_C = out_dim(IMG_C, K, STRIDE);
  localparam int CW    = 16;

  logic [CW-1:0] kr;
  logic [CW-1:0] kc;
  logic [CW-1:0] orow;
  logic [CW-1:0] ocol;
  logic          last_kc;
  logic          last_col;

  assign last_kc  = (kc == CW'(K - 1));
  assign last_tap = last_kc && (kr == CW'(K - 1));
  assign last_col = (ocol == CW'(OUT_C - 1));
  assign last_out = last_col && (orow == CW'(OUT_R - 1));

  // Pixel address of the current tap; ROM_AW covers the image so the
  // modulo-2^ROM_AW arithmetic is exact.
  assign rom_addr = (ROM_AW'(orow) * ROM_AW'(STRIDE) + ROM_AW'(kr)) * ROM_AW'(IMG_C)
                  + ROM_AW'(ocol) * ROM_AW'(STRIDE) + ROM_AW'(kc);

  // Advance kernel column, kernel row, then output position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kr      <= '0;
      kc      <= '0;
      orow    <= '0;
      ocol    <= '0;
      tap     <= '0;
      out_idx <= '0;
    end else if (clear) begin
      kr      <= '0;
      kc      <= '0;
      orow    <= '0;
      ocol    <= '0;
      tap     <= '0;
      out_idx <= '0;
    end else if (step && !(last_tap && last_out)) begin
      if (!last_kc) begin
        kc  <= kc + 1'b1;
        tap <= tap + 1'b1;
      end else begin
        kc <= '0;
        if (kr != CW'(K - 1)) begin
          kr  <= kr + 1'b1;
          tap <= tap + 1'b1;
        end else begin
          kr      <= '0;
          tap     <= '0;
          out_idx <= out_idx + 1'b1;
          if (!last_col) begin
            ocol <= ocol + 1'b1;
          end else begin
            ocol <= '0;
            orow <= orow + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// Streaming valid-mode 2D convolution engine. Pixels come from an async-read
// ROM, one kernel tap per clock; each finished output is saturated and
// written to an internal result RAM readable at any time.
// Optional build macro CONV_RELU_EN: store max(0, sat(sum)) instead of sat(sum).
// Handshake: start is a level; IDLE->RUN when start=1, RUN ignores start,
// DONE holds done=1 until start=0, which returns to IDLE on that edge.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int IMG_R  = 10,
  parameter int IMG_C  = 12,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int PIX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int ROM_AW = 8,
  parameter int OUT_AW = 7,
  localparam int TAP_W = (K * K > 1) ? $clog2(K * K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_signed,
  input  logic              kernel_we,
  input  logic [TAP_W-1:0]  kernel_idx,
  input  logic [DATA_W-1:0] kernel_data,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic [OUT_AW-1:0] out_rd_addr,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycles,
  output logic              sat_flag,
  output conv_state_e       state_dbg
);

  localparam int OUT_N = out_count(IMG_R, IMG_C, K, STRIDE);
  localparam int PW    = DATA_W + PIX_W + 1;

  conv_state_e state;
  conv_state_e state_nx;
  logic        addr_clear;
  logic        addr_step;

  logic [TAP_W-1:0]  tap;
  logic [OUT_AW-1:0] out_idx;
  logic              last_tap;
  logic              last_out;

  logic                     pix_sgn;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] kern [2**TAP_W];
  logic signed [DATA_W-1:0] out_mem [2**OUT_AW];

  logic [PIX_W-1:0]         pix_raw;
  logic signed [PIX_W:0]    pix_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [SAT_W-1:0]  sat_full;
  logic                     clamped;
  logic signed [DATA_W-1:0] res_store;
  logic                     rom_data_unused;

  conv_addr_gen #(
    .IMG_R  (IMG_R),
    .IMG_C  (IMG_C),
    .K      (K),
    .STRIDE (STRIDE),
    .ROM_AW (ROM_AW),
    .OUT_AW (OUT_AW),
    .TAP_W  (TAP_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clear    (addr_clear),
    .step     (addr_step),
    .rom_addr (rom_addr),
    .tap      (tap),
    .out_idx  (out_idx),
    .last_tap (last_tap),
    .last_out (last_out)
  );

  // Only the low PIX_W bits of a ROM word carry pixel data.
  assign rom_data_unused = ^rom_data[31:PIX_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and counter control.
  always_comb begin
    state_nx   = state;
    addr_clear = 1'b0;
    addr_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx   = ST_RUN;
          addr_clear = 1'b1;
        end
      end
      ST_RUN: begin
        addr_step = 1'b1;
        if (last_tap && last_out) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (!start) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // MAC and saturation for the current tap.
  always_comb begin
    pix_raw   = rom_data[PIX_W-1:0];
    pix_ext   = {pix_sgn & pix_raw[PIX_W-1], pix_raw};
    prod      = PW'(kern[tap]) * PW'(pix_ext);
    sum       = acc + ACC_W'(prod);
    sat_full  = saturate(SAT_W'(sum), DATA_W, clamped);
    res_store = DATA_W'(sat_full);
`ifdef CONV_RELU_EN
    if (sat_full < 0) res_store = '0;
`else
`endif
  end

  // Run bookkeeping: accumulator, cycle counter, sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cycles   <= '0;
      sat_flag <= 1'b0;
      pix_sgn  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc      <= '0;
            cycles   <= '0;
            sat_flag <= 1'b0;
            pix_sgn  <= pix_signed;
          end
        end
        ST_RUN: begin
          cycles <= cycles + 32'd1;
          if (last_tap) begin
            acc <= '0;
            if (clamped) sat_flag <= 1'b1;
          end else begin
            acc <= sum;
          end
        end
        default: ;
      endcase
    end
  end

  // Result RAM: one write per completed output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**OUT_AW; i++) out_mem[i] <= '0;
    end else if (state == ST_RUN && last_tap) begin
      out_mem[out_idx] <= res_store;
    end
  end

  // Kernel register file; writable only outside RUN and for valid indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**TAP_W; i++) kern[i] <= '0;
    end else if (state != ST_RUN && kernel_we && 32'(kernel_idx) < K * K) begin
      kern[kernel_idx] <= kernel_data;
    end
  end

  assign out_rd_data = (32'(out_rd_addr) < OUT_N) ? out_mem[out_rd_addr] : '0;
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign state_dbg   = state;

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
- Parametrised successor to the fixed 10x12 / 3x3 convolution unit.
- Streams image pixels from an external async-read ROM and performs a valid-mode 2D convolution with a KxK signed kernel held in a register file.
- Applies a configurable stride.
- Stores saturated results in an internal output RAM that the display/controller path reads back; reports the compute cycle count.

Parameters:
- IMG_R, 10, image rows
- IMG_C, 12, image columns
- K, 3, kernel edge (kernel is KxK, K>=1, K<=IMG_R, K<=IMG_C)
- STRIDE, 1, output step in both dimensions (>=1)
- PIX_W, 4, pixel bits taken from rom_data[PIX_W-1:0]
- DATA_W, 32, kernel coefficient and stored result width (signed)
- ACC_W, 64, accumulator width (signed)
- ROM_AW, 8, ROM address width (must cover IMG_R*IMG_C)
- OUT_AW, 7, output read address width (must cover OUT_N)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level request to begin a run
- pix_signed  in  1  1 = pixels are two's complement PIX_W, 0 = unsigned; sampled at start
- kernel_we  in  1  kernel write strobe
- kernel_idx  in  clog2(K*K)  coefficient index, row-major
- kernel_data  in  DATA_W  signed coefficient
- rom_addr  out  ROM_AW  image address
- rom_data  in  32  pixel word; combinational function of rom_addr
- out_rd_addr  in  OUT_AW  result read address
- out_rd_data  out  DATA_W  signed result, combinational read
- busy  out  1  high in RUN
- done  out  1  completion level
- cycles  out  32  RUN-cycle count of last/current run
- sat_flag  out  1  sticky: any result saturated in current/last run

Behaviour:
- Derived: OUT_R=(IMG_R-K)/STRIDE+1, OUT_C=(IMG_C-K)/STRIDE+1, OUT_N=OUT_R*OUT_C.
- Reset (async): state IDLE; rom_addr=0, busy=0, done=0, cycles=0, sat_flag=0; kernel and out_mem cleared to 0; counters cleared. Reset mid-RUN aborts immediately; no partial write survives.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, clear cycles, sat_flag, acc and counters; latch pix_signed; load rom_addr with the address of (out 0,0, tap 0); go to RUN.
- RUN: one tap per cycle.
  - cycles+=1; acc+=kernel[tap]*pixel.
  - rom_addr takes the next tap's address, so data always aligns with the current tap.
  - Address = (out_r*STRIDE+kr)*IMG_C + out_c*STRIDE+kc.
  - Taps row-major; outputs row-major.
- On the last tap (K*K-1): write sat(acc+prod) to out_mem[out_r*OUT_C+out_c]; clear acc; advance output. After output OUT_N-1, go to DONE.
- Total RUN cycles = OUT_N*K*K (defaults: 720).
- Pixel: zero-extended if pix_signed=0, sign-extended if 1. Product is full precision, accumulation in ACC_W.
- Saturation: the ACC_W sum is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp sets sat_flag.
- DONE: done=1, cycles frozen; when start=0, go to IDLE with done=0 on that edge. Holding start high keeps DONE (no auto-restart).
- start while in RUN is ignored.
- kernel_we: accepted in IDLE/DONE when kernel_idx<K*K. Ignored in RUN and for out-of-range indices.
- out_rd_data: 0 when out_rd_addr>=OUT_N. Readable in any state. Entries not yet rewritten in the current run hold their previous values.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: the stored value is max(0, sat(sum)). A negative sum stores 0; sat_flag is still set by negative clamps.
- Undefined: the signed saturated value is stored unchanged.

Decomposition:
- Shared package conv_pkg: state encoding (IDLE/RUN/DONE), derived-size functions (OUT_R/OUT_C/OUT_N), saturate function.
- One sub-module, conv_addr_gen: the tap/output counters and next-address logic. It emits rom_addr, the current tap index, the last-tap flag and the last-output flag.
- MAC, saturation, memories and FSM stay in conv2d_engine.

Test Plan:
- Defaults, kernel all 1, image all 15, unsigned -> every out = 135; cycles = 720; done high until start drops; sat_flag=0.
- Kernel centre=1, others 0; image pixel(r,c)=(r+c)%16 -> out(r,c) = (r+c+2)%16; out_rd_addr=80 -> 0.
- pix_signed=1, image all 4'hF (-1), kernel all 2 -> every out = -18; with CONV_RELU_EN -> 0.
- DATA_W=8, kernel all 127, image all 15 -> results clamp to 127; sat_flag=1.
- STRIDE=2, K=3, 10x12 -> OUT_R=4, OUT_C=5; cycles=180. Address sequence for output (0,1) begins 2,3,4,14.
- Mid-RUN: pulse start (ignored) and kernel_we (kernel unchanged), then assert rst -> all outputs at reset values, out_mem=0; a fresh run succeeds.
